// File: rtl/spike_event_monitor.sv
// Spike readout: edge-detects two spike lines, keeps saturating counts, and buffers
// timestamped event words in a FIFO drained over valid/ready. Optional rate window: SPIKE_MON_RATE_EN.
module spike_event_monitor #(
  parameter int TS_W       = 16,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 16,
  parameter int WIN_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     spike_n1,
  input  logic                     spike_n2,
  input  logic                     clr_cnt,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [TS_W+2:0]          ev_data,
  output logic [CNT_W-1:0]         cnt_n1,
  output logic [CNT_W-1:0]         cnt_n2,
  output logic [7:0]               drop_cnt,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               rate_n1,
  output logic [7:0]               rate_n2,
  output logic                     rate_strobe
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]       PTR_ONE = (AW+1)'(1);
  localparam logic [TS_W-1:0]   TS_ONE  = TS_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  typedef struct packed {
    logic            wrap;
    logic            m2;
    logic            m1;
    logic [TS_W-1:0] ts;
  } event_t;

  logic            s1_q, s2_q;
  logic            rise_n1, rise_n2;
  logic            m1, m2;
  logic [TS_W-1:0] ts;
  logic            wrap_q;
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            full, pop, push_req, push_ok, drop;
  event_t          push_word;
  event_t          mem [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= spike_n1;
      s2_q <= spike_n2;
    end
  end

  assign rise_n1 = spike_n1 & ~s1_q;
  assign rise_n2 = spike_n2 & ~s2_q;
  assign m1      = ena & rise_n1;
  assign m2      = ena & rise_n2;

  // wrap_q marks the first enabled cycle at ts==0 after a rollover; it holds across ena=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts     <= '0;
      wrap_q <= 1'b0;
    end else if (ena) begin
      ts     <= ts + TS_ONE;
      wrap_q <= (ts == '1);
    end
  end

  assign ev_valid   = (wr_ptr != rd_ptr);
  assign fifo_level = wr_ptr - rd_ptr;
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = ev_valid & ev_ready;

  always_comb begin
    // NOTE: defaults first so no path through this block leaves a value unassigned (no latch).
    push_word = '0;
    push_req  = 1'b0;
    push_ok   = 1'b0;
    drop      = 1'b0;
    if (ena && (rise_n1 || rise_n2 || wrap_q)) begin
      push_req       = 1'b1;
      push_word.wrap = wrap_q;
      push_word.m2   = rise_n2;
      push_word.m1   = rise_n1;
      push_word.ts   = ts;
    end
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    push_ok = push_req & (~full | pop);
    drop    = push_req & full & ~pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is not reset; emptiness comes from the pointers and ev_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  assign ev_data = ev_valid ? mem[rd_ptr[AW-1:0]] : '0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && v != '1) ? v + CNT_ONE : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_n1   <= '0;
      cnt_n2   <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (clr_cnt) begin
      cnt_n1   <= CNT_W'(m1);
      cnt_n2   <= CNT_W'(m2);
      drop_cnt <= {7'd0, drop};
      overflow <= drop;
    end else begin
      cnt_n1 <= sat_inc(cnt_n1, m1);
      cnt_n2 <= sat_inc(cnt_n2, m2);
      if (drop) begin
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        overflow <= 1'b1;
      end
    end
  end

`ifdef SPIKE_MON_RATE_EN
  localparam int WIN_W = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);

  logic [WIN_W-1:0] win_cnt;
  logic [7:0]       acc_n1, acc_n2;

  function automatic logic [7:0] sat8_inc(input logic [7:0] v, input logic inc);
    return (inc && v != 8'hFF) ? v + 8'd1 : v;
  endfunction

  // The closing cycle's rise is folded into the published rate, not the next window.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt     <= '0;
      acc_n1      <= '0;
      acc_n2      <= '0;
      rate_n1     <= '0;
      rate_n2     <= '0;
      rate_strobe <= 1'b0;
    end else begin
      rate_strobe <= 1'b0;
      if (clr_cnt) begin
        win_cnt <= '0;
        acc_n1  <= '0;
        acc_n2  <= '0;
      end else if (ena) begin
        if (win_cnt == WIN_LAST) begin
          win_cnt     <= '0;
          rate_n1     <= sat8_inc(acc_n1, m1);
          rate_n2     <= sat8_inc(acc_n2, m2);
          acc_n1      <= '0;
          acc_n2      <= '0;
          rate_strobe <= 1'b1;
        end else begin
          win_cnt <= win_cnt + WIN_W'(1);
          acc_n1  <= sat8_inc(acc_n1, m1);
          acc_n2  <= sat8_inc(acc_n2, m2);
        end
      end
    end
  end
`else
  logic unused_win;
  assign unused_win  = (WIN_CYCLES > 0);
  assign rate_n1     = '0;
  assign rate_n2     = '0;
  assign rate_strobe = 1'b0;
`endif

endmodule
